seq_serializer: RTL and testbench
=================================

SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits; legal range 2..16.
REQ-002 Parameter GAP, default 0: idle cycles inserted between consecutive words; legal range 0..15.
REQ-003 Parameter IDLE_BIT, default 1'b0: value driven on seq_out whenever seq_valid is low.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, synchronous to clk, active-high.
REQ-006 data_in  input  WIDTH  parallel word to serialize.
REQ-007 data_valid  input  1  data_in holds a word offered for transfer.
REQ-008 data_ready  output  1  block can accept a word this cycle.
REQ-009 seq_out  output  1  serial bit stream, MSB first; feeds the sequence detector's seq_in.
REQ-010 seq_valid  output  1  seq_out carries a data bit this cycle.
REQ-011 busy  output  1  high when state is not IDLE or the hold register is full.
REQ-012 state_out  output  2  current FSM state encoding, for debug.

Function
REQ-013 A word transfers on a rising edge where data_valid and data_ready are both high; no other edge transfers data.
REQ-014 FSM states: IDLE=2'd0, SHIFT=2'd1, GAP=2'd2; encoding 2'd3 is illegal and returns to IDLE on the next edge.
REQ-015 Datapath: WIDTH-bit shift register, bit counter of $clog2(WIDTH) bits, 4-bit gap counter, and a one-word hold register with a full flag.
REQ-016 data_ready = !reset && !hold_full, derived only from registered state, with no combinational path from data_valid.
REQ-017 IDLE: a transfer loads the word into the shift register and moves to SHIFT with the bit counter at 0; the hold register stays empty.
REQ-018 seq_out and seq_valid are registered; the MSB appears in the cycle after the transfer edge (latency 1), and bit i (MSB=0) appears i+1 cycles after that edge.
REQ-019 SHIFT: seq_valid=1 every cycle, one bit per cycle, MSB first; the bit counter increments and the last bit is counter = WIDTH-1.
REQ-020 A transfer during SHIFT, or during GAP, writes the hold register and sets hold_full.
REQ-021 At the last bit with GAP=0, the next word loads with zero bubble: from hold if hold_full (clearing it), else directly from an accepted transfer on the same edge, else the FSM goes to IDLE.
REQ-022 At the last bit with GAP>0, the FSM goes to GAP, and the gap counter counts GAP cycles at seq_valid=0 and seq_out=IDLE_BIT.
REQ-023 At the end of GAP, the reload priority of REQ-021 applies (hold first, then direct transfer, else IDLE).
REQ-024 If hold_full and the hold is consumed on the same edge, hold_full clears, data_ready returns high the next cycle, and no word is lost or duplicated.
REQ-025 Outside SHIFT, seq_valid=0 and seq_out=IDLE_BIT.
REQ-026 Words serialize strictly in transfer order, with at most 2 words in flight (shifter + hold).
REQ-027 data_in changes while data_valid is low, or after its transfer edge, have no effect.

Reset
REQ-028 Reset high at a rising edge forces state=IDLE, hold_full=0, both counters=0, seq_valid=0, seq_out=IDLE_BIT, and busy=0 on the following cycle.
REQ-029 data_ready=0 while reset is high; a transfer attempted during reset is dropped.
REQ-030 Reset mid-word aborts the word; no remaining bits are emitted and the hold register is discarded.
REQ-031 Outputs are defined from the first edge with reset high; no X appears on outputs after that edge.

Verification
REQ-032 WIDTH=8, GAP=0, 8'hA5 transferred at edge N -> seq_out 1,0,1,0,0,1,0,1 with seq_valid=1 on cycles N+1..N+8, then seq_valid=0 and state_out=0.
REQ-033 Back-to-back 8'hA0 then 8'h5F with data_valid held high -> 16 contiguous valid bits 10100000_01011111; data_ready=0 while the hold is full; 8'h5F is not duplicated.
REQ-034 GAP=2, words 8'hFF and 8'h01 -> 8 ones, 2 cycles of seq_valid=0/seq_out=IDLE_BIT, then 00000001.
REQ-035 Reset asserted on the 4th bit of 8'hC3 with 8'h81 held -> next cycle seq_valid=0, state_out=0, busy=0; after release, 8'h3C serializes cleanly as 00111100.
REQ-036 data_valid dropped for 5 cycles between words -> IDLE for 4 cycles with seq_out=IDLE_BIT; the next word's MSB appears 1 cycle after its transfer.
REQ-037 Integration: serializer feeding the sequence detector, with 8'hA0 sent twice -> detector asserts detected exactly once per word (at bit 3) and never during idle cycles.

Source files
------------

// File: rtl/seq_serializer_if.sv
// seq_serializer_if: parallel word in (data_in/data_valid/data_ready), serial out (seq_out/seq_valid), status (busy/state_out)
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic data_valid;
    logic data_ready;
    logic seq_out;
    logic seq_valid;
    logic busy;
    logic [1:0] state_out;
    modport master(output data_in, data_valid, input data_ready, seq_out, seq_valid, busy, state_out);
    modport slave(input data_in, data_valid, output data_ready, seq_out, seq_valid, busy, state_out);
endinterface

// File: rtl/seq_serializer.sv
// seq_serializer: MSB-first word serializer with one-word hold and GAP idle cycles (clk, reset, bus: data_in/data_valid/data_ready in, seq_out/seq_valid/busy/state_out out)
module seq_serializer #(
    parameter int WIDTH = 8,
    parameter int GAP = 0,
    parameter logic IDLE_BIT = 1'b0
) (
    input logic clk,
    input logic reset,
    seq_serializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [3:0] GLAST = GAP == 0 ? 4'd0 : 4'(GAP - 1);
    logic [1:0] state, state_n;
    logic [WIDTH-1:0] sh, sh_n, hold, hold_n, word;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0] gcnt, gcnt_n;
    logic full, full_n, out, valid;
    logic take, last, reload, load, to_hold;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            sh <= '0;
            hold <= '0;
            cnt <= '0;
            gcnt <= '0;
            full <= 1'b0;
            out <= IDLE_BIT;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            sh <= sh_n;
            hold <= hold_n;
            cnt <= cnt_n;
            gcnt <= gcnt_n;
            full <= full_n;
            out <= state_n == S_SHIFT ? sh_n[WIDTH-1] : IDLE_BIT;
            valid <= state_n == S_SHIFT;
        end
    end
    // reload: end of a word (GAP=0) or end of the gap; hold wins over a same-edge transfer
    always_comb begin
        take = bus.data_valid && bus.data_ready;
        last = state == S_SHIFT && cnt == LAST;
        reload = (last && GAP == 0) || (state == S_GAP && gcnt == GLAST);
        load = (state == S_IDLE && take) || (reload && (full || take));
        to_hold = take && (state == S_SHIFT || state == S_GAP) && !load;
        word = full ? hold : bus.data_in;
        state_n = load ? S_SHIFT : (reload || state == 2'd3) ? S_IDLE : last ? S_GAP : state;
        sh_n = load ? word : state == S_SHIFT ? sh << 1 : sh;
        cnt_n = state == S_SHIFT && !last ? cnt + 1'b1 : '0;
        gcnt_n = state == S_GAP && !reload ? gcnt + 1'b1 : '0;
        full_n = to_hold ? 1'b1 : (reload && full) ? 1'b0 : full;
        hold_n = to_hold ? bus.data_in : hold;
    end
    always_comb begin
        bus.data_ready = !reset && !full;
        bus.busy = state != S_IDLE || full;
        bus.seq_out = out;
        bus.seq_valid = valid;
        bus.state_out = state;
    end
endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: table, directed and random checks of two serializers (GAP=0 and GAP=2) against a word-schedule model
module tb_seq_serializer;
    localparam int W = 8;
    typedef struct {
        logic dv;
        logic [W-1:0] din;
        logic v;
        logic o;
        logic [1:0] st;
        logic rdy;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dv = 1'b0;
    logic [W-1:0] din = '0;
    int pass = 0;
    int total = 0;
    int e = 0;
    int gp[2] = '{0, 2};
    logic ib[2] = '{1'b0, 1'b1};
    bit lv[2][4];
    int lt[2][4];
    int ll[2][4];
    logic [W-1:0] lw[2][4];
    int nx[2] = '{0, 0};
    int lastl[2] = '{0, 0};
    bit has[2] = '{0, 0};
    vec_t tv[40];
    int nt = 0;
    always #5 clk = ~clk;
    seq_serializer_if #(.WIDTH(W)) b0();
    seq_serializer_if #(.WIDTH(W)) b1();
    assign b0.data_in = din;
    assign b0.data_valid = dv;
    assign b1.data_in = din;
    assign b1.data_valid = dv;
    seq_serializer #(.WIDTH(W), .GAP(0), .IDLE_BIT(1'b0)) u0 (.clk(clk), .reset(reset), .bus(b0));
    seq_serializer #(.WIDTH(W), .GAP(2), .IDLE_BIT(1'b1)) u1 (.clk(clk), .reset(reset), .bus(b1));
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    endtask
    task automatic add(input logic d, input logic [W-1:0] x, input logic v, input logic o, input logic [1:0] st, input logic r);
        tv[nt] = '{d, x, v, o, st, r};
        nt++;
    endtask
    // Each accepted word k is loaded into the shifter at edge L = max(t, L_prev + W + GAP);
    // it is serialized in the periods after edges L..L+W-1, gapped after L+W..L+W+GAP-1,
    // and sits in the hold register in the periods after edges t..L-1.
    function automatic void model(input int d, output logic v, output logic o, output logic [1:0] st, output logic hf);
        v = 1'b0;
        o = ib[d];
        st = 2'd0;
        hf = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int l;
            l = ll[d][k];
            if (lv[d][k]) begin
                if (e >= l && e < l + W) begin
                    v = 1'b1;
                    o = lw[d][k][W-1-(e-l)];
                    st = 2'd1;
                end else if (e >= l + W && e < l + W + gp[d]) st = 2'd2;
                if (lt[d][k] <= e && e < l) hf = 1'b1;
            end
        end
    endfunction
    initial begin
        logic v, o, hf, rdy;
        logic [1:0] st;
        bit acc[2];
        bit seen;
        int l, k;
        seen = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                model(d, v, o, st, hf);
                rdy = !reset && !hf;
                if (seen) begin
                    chk($sformatf("u%0d seq_valid", d), d == 0 ? b0.seq_valid : b1.seq_valid, v);
                    chk($sformatf("u%0d seq_out", d), d == 0 ? b0.seq_out : b1.seq_out, o);
                    chk($sformatf("u%0d state_out", d), d == 0 ? b0.state_out : b1.state_out, st);
                    chk($sformatf("u%0d busy", d), d == 0 ? b0.busy : b1.busy, st != 2'd0 || hf);
                    chk($sformatf("u%0d data_ready", d), d == 0 ? b0.data_ready : b1.data_ready, rdy);
                end
                acc[d] = rdy && dv;
            end
            for (int d = 0; d < 2; d++) begin
                if (reset) begin
                    for (int j = 0; j < 4; j++) lv[d][j] = 0;
                    has[d] = 0;
                end else if (acc[d]) begin
                    l = (has[d] && lastl[d] + W + gp[d] > e + 1) ? lastl[d] + W + gp[d] : e + 1;
                    k = nx[d] % 4;
                    lv[d][k] = 1;
                    lt[d][k] = e + 1;
                    ll[d][k] = l;
                    lw[d][k] = din;
                    nx[d]++;
                    lastl[d] = l;
                    has[d] = 1;
                end
            end
            if (reset) seen = 1;
            e++;
        end
    end
    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic ev[18];
        logic eo[18];
        logic [1:0] es[18];
        int rate;
        add(1'b1, 8'hA5, 1'b0, 1'b0, 2'd0, 1'b1);
        a = 8'hA5;
        for (int i = 0; i < 8; i++) add(1'b0, 8'h00, 1'b1, a[W-1-i], 2'd1, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);
        add(1'b1, 8'hA0, 1'b0, 1'b0, 2'd0, 1'b1);
        a = 8'hA0;
        for (int i = 0; i < 8; i++) add(1'b1, 8'h5F, 1'b1, a[W-1-i], 2'd1, i == 0);
        b = 8'h5F;
        for (int i = 0; i < 8; i++) add(1'b0, 8'h00, 1'b1, b[W-1-i], 2'd1, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);
        a = 8'h01;
        for (int i = 0; i < 18; i++) begin
            ev[i] = i < 8 || i >= 10;
            eo[i] = i < 8 ? 1'b1 : i < 10 ? 1'b1 : a[W-1-(i-10)];
            es[i] = i < 8 || i >= 10 ? 2'd1 : 2'd2;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < nt; i++) begin
            dv = tv[i].dv;
            din = tv[i].din;
            @(negedge clk);
            chk($sformatf("tbl[%0d] seq_valid", i), b0.seq_valid, tv[i].v);
            chk($sformatf("tbl[%0d] seq_out", i), b0.seq_out, tv[i].o);
            chk($sformatf("tbl[%0d] state_out", i), b0.state_out, tv[i].st);
            chk($sformatf("tbl[%0d] data_ready", i), b0.data_ready, tv[i].rdy);
            chk($sformatf("tbl[%0d] busy", i), b0.busy, tv[i].st != 2'd0 || !tv[i].rdy);
            @(posedge clk);
            #1;
        end
        dv = 1'b0;
        repeat (20) @(posedge clk);
        #1 dv = 1'b1;
        din = 8'hFF;
        @(posedge clk);
        #1 din = 8'h01;
        @(negedge clk);
        chk("gap[0] seq_valid", b1.seq_valid, ev[0]);
        chk("gap[0] seq_out", b1.seq_out, eo[0]);
        @(posedge clk);
        #1 dv = 1'b0;
        for (int i = 1; i < 18; i++) begin
            @(negedge clk);
            chk($sformatf("gap[%0d] seq_valid", i), b1.seq_valid, ev[i]);
            chk($sformatf("gap[%0d] seq_out", i), b1.seq_out, eo[i]);
            chk($sformatf("gap[%0d] state_out", i), b1.state_out, es[i]);
        end
        repeat (20) @(posedge clk);
        #1 dv = 1'b1;
        din = 8'hC3;
        @(posedge clk);
        #1 din = 8'h81;
        @(posedge clk);
        #1 dv = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        dv = 1'b1;
        din = 8'h3C;
        @(negedge clk);
        chk("rst seq_valid", b0.seq_valid, 1'b0);
        chk("rst state_out", b0.state_out, 2'd0);
        chk("rst busy", b0.busy, 1'b0);
        @(posedge clk);
        #1 dv = 1'b0;
        a = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("rst 3C bit%0d valid", i), b0.seq_valid, 1'b1);
            chk($sformatf("rst 3C bit%0d out", i), b0.seq_out, a[W-1-i]);
        end
        @(negedge clk);
        chk("rst after 3C seq_valid", b0.seq_valid, 1'b0);
        rate = 50;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (c % 100 == 0) rate = $urandom_range(0, 2) == 0 ? 10 : $urandom_range(0, 1) == 0 ? 50 : 95;
            reset = $urandom_range(0, 96) == 0;
            dv = $urandom_range(0, 99) < rate;
            din = W'($urandom);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        dv = 1'b0;
        repeat (30) @(posedge clk);
        #1 $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
